ga22_sprite_line_fetch: RTL and testbench

//  Per-scanline sprite walker that feeds the drawing port of double_linebuf. On start it reads the sprite attribute table.
//  For each sprite intersecting the line it fetches one 64-bit 4-plane row per 16-px column from sprite ROM.
//  It then issues one draw write (bits/color/prio/pos/we) per column, with writes spaced for the 2-px/clk buffer drain.

---
 rtl/ga22_sprite_line_fetch.sv | 222 ++++++++++++++++++++++
 tb/tb_ga22_sprite_line_fetch.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ga22_sprite_line_fetch.sv
// Per-scanline sprite walker: attribute scan, one ROM row fetch per 16-px column, paced draw strobes.
// Draw writes are >= 8 clks apart; rom_req waits on rom_ack. GA22_SPRITE_LIMIT_EN caps sprites per line.
module ga22_sprite_line_fetch #(
    parameter int NUM_SPRITES          = 256,
    parameter int MAX_SPRITES_PER_LINE = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [8:0]  line,
    output logic        busy,
    output logic        done,
    output logic [11:0] obj_addr,
    input  logic [15:0] obj_data,
    output logic [19:0] rom_addr,
    output logic        rom_req,
    input  logic        rom_ack,
    input  logic [63:0] rom_data,
    output logic [63:0] bits,
    output logic [6:0]  color,
    output logic        prio,
    output logic [9:0]  pos,
    output logic        we
);
    typedef enum logic [2:0] {
        S_IDLE, S_ATTR, S_CHECK, S_FETCH, S_WAIT, S_EMIT, S_NEXT, S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [8:0]  line_q;
    logic [9:0]  idx;
    logic [2:0]  widx;
    logic [8:0]  spr_y;
    logic [1:0]  spr_h, spr_w;
    logic [15:0] code;
    logic [6:0]  color_q;
    logic        prio_q, flipx, flipy;
    logic [9:0]  x_q;
    logic [6:0]  row_q;
    logic [1:0]  col;
    logic [2:0]  gap;
    logic        restart_pend;
    logic [63:0] data_q;
    logic        walk_reset, fetch_go, emit_go, cap_hit;

    logic [8:0]  rel;
    logic [7:0]  height;
    logic        visible;
    logic [6:0]  row_c;
    logic [1:0]  cols_m1, col_eff;
    logic [15:0] tile;
    logic        last_idx, last_col;

    assign rel      = line_q - spr_y;
    assign height   = 8'd16 << spr_h;
    assign visible  = rel < {1'b0, height};
    // 7-bit wrap makes height-1-rel correct even for height=128
    assign row_c    = flipy ? (height[6:0] - 7'd1 - rel[6:0]) : rel[6:0];
    assign cols_m1  = (spr_w == 2'd0) ? 2'd0 : (spr_w == 2'd1) ? 2'd1 : 2'd3;
    assign col_eff  = flipx ? (cols_m1 - col) : col;
    assign tile     = code + {13'd0, row_q[6:4]} + {11'd0, col_eff, 3'b000};
    assign last_idx = (idx == 10'(NUM_SPRITES - 1));
    assign last_col = (col == cols_m1);

`ifdef GA22_SPRITE_LIMIT_EN
    logic [10:0] vis_cnt;
    assign cap_hit = (vis_cnt == 11'(MAX_SPRITES_PER_LINE - 1));
`else
    assign cap_hit = 1'b0;
`endif

    function automatic logic [63:0] plane_rev(input logic [63:0] d);
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 16; i++)
                plane_rev[p*16+i] = d[p*16+15-i];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b1;
        done       = 1'b0;
        obj_addr   = 12'd0;
        walk_reset = 1'b0;
        fetch_go   = 1'b0;
        emit_go    = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin state_nxt = S_ATTR; walk_reset = 1'b1; end
            end
            S_ATTR: begin
                if (widx < 3'd4) obj_addr = {idx, widx[1:0]};
                if (start)              begin state_nxt = S_ATTR; walk_reset = 1'b1; end
                else if (widx == 3'd4)  state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (start)        begin state_nxt = S_ATTR; walk_reset = 1'b1; end
                else if (visible) state_nxt = S_FETCH;
                else              state_nxt = S_NEXT;
            end
            S_FETCH: begin
                if (start) begin state_nxt = S_ATTR; walk_reset = 1'b1; end
                else       begin state_nxt = S_WAIT; fetch_go = 1'b1; end
            end
            S_WAIT: begin
                // an in-flight ROM read always completes; a pending restart drops its data
                if (rom_ack) begin
                    if (start || restart_pend) begin state_nxt = S_ATTR; walk_reset = 1'b1; end
                    else                       state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (start) begin
                    state_nxt  = S_ATTR;
                    walk_reset = 1'b1;
                end else if (gap == 3'd0) begin
                    emit_go = 1'b1;
                    if (!last_col)    state_nxt = S_FETCH;
                    else if (cap_hit) state_nxt = S_DONE;
                    else              state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                if (start)         begin state_nxt = S_ATTR; walk_reset = 1'b1; end
                else if (last_idx) state_nxt = S_DONE;
                else               state_nxt = S_ATTR;
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) begin state_nxt = S_ATTR; walk_reset = 1'b1; end
                else       state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            line_q <= '0; idx <= '0; widx <= '0; spr_y <= '0; spr_h <= '0; spr_w <= '0;
            code <= '0; color_q <= '0; prio_q <= 1'b0; flipx <= 1'b0; flipy <= 1'b0;
            x_q <= '0; row_q <= '0; col <= '0; gap <= '0; restart_pend <= 1'b0;
            data_q <= '0; rom_addr <= '0; rom_req <= 1'b0;
            bits <= '0; color <= '0; prio <= 1'b0; pos <= '0; we <= 1'b0;
`ifdef GA22_SPRITE_LIMIT_EN
            vis_cnt <= '0;
`endif
        end else begin
            we    <= 1'b0;
            bits  <= '0;
            color <= '0;
            prio  <= 1'b0;
            pos   <= '0;
            if (gap != 3'd0) gap <= gap - 3'd1;
            if (start) line_q <= line;
            if (start && state == S_WAIT && !rom_ack) restart_pend <= 1'b1;
            case (state)
                S_ATTR: begin
                    widx <= widx + 3'd1;
                    case (widx)
                        3'd1: begin
                            spr_y <= obj_data[8:0];
                            spr_h <= obj_data[10:9];
                            spr_w <= obj_data[12:11];
                        end
                        3'd2: code <= obj_data;
                        3'd3: begin
                            color_q <= obj_data[6:0];
                            prio_q  <= obj_data[7];
                            flipx   <= obj_data[8];
                            flipy   <= obj_data[9];
                        end
                        3'd4: x_q <= obj_data[9:0];
                        default: ;
                    endcase
                end
                S_CHECK: begin
                    row_q <= row_c;
                    col   <= 2'd0;
                end
                S_FETCH: if (fetch_go) begin
                    rom_req  <= 1'b1;
                    rom_addr <= {tile, row_q[3:0]};
                end
                S_WAIT: if (rom_ack) begin
                    rom_req <= 1'b0;
                    data_q  <= rom_data;
                end
                S_EMIT: if (emit_go) begin
                    we    <= 1'b1;
                    bits  <= flipx ? plane_rev(data_q) : data_q;
                    color <= color_q;
                    prio  <= prio_q;
                    pos   <= x_q + {4'd0, col, 4'd0};
                    gap   <= 3'd7;
                    col   <= col + 2'd1;
`ifdef GA22_SPRITE_LIMIT_EN
                    if (last_col) vis_cnt <= vis_cnt + 11'd1;
`endif
                end
                S_NEXT: if (!last_idx) begin
                    idx  <= idx + 10'd1;
                    widx <= 3'd0;
                end
                default: ;
            endcase
            if (walk_reset) begin
                idx          <= '0;
                widx         <= '0;
                restart_pend <= 1'b0;
`ifdef GA22_SPRITE_LIMIT_EN
                vis_cnt      <= '0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_ga22_sprite_line_fetch.sv
// Directed bench for ga22_sprite_line_fetch: attribute RAM and ROM models, draw-write monitor.
module tb_ga22_sprite_line_fetch;
    localparam int NS   = 4;
    localparam int MAXS = 2;

    logic        clk = 1'b0;
    logic        reset, start, prio, we, busy, done, rom_req, rom_ack;
    logic [8:0]  line;
    logic [11:0] obj_addr;
    logic [15:0] obj_data;
    logic [19:0] rom_addr;
    logic [63:0] rom_data, bits;
    logic [6:0]  color;
    logic [9:0]  pos;

    always #5 clk = ~clk;

    ga22_sprite_line_fetch #(.NUM_SPRITES(NS), .MAX_SPRITES_PER_LINE(MAXS)) dut (
        .clk(clk), .reset(reset), .start(start), .line(line), .busy(busy), .done(done),
        .obj_addr(obj_addr), .obj_data(obj_data), .rom_addr(rom_addr), .rom_req(rom_req),
        .rom_ack(rom_ack), .rom_data(rom_data), .bits(bits), .color(color), .prio(prio),
        .pos(pos), .we(we)
    );

    typedef struct {
        logic [63:0] b;
        logic [6:0]  c;
        logic        p;
        logic [9:0]  x;
        int          cyc;
    } wrec_t;

    logic [15:0] attr_mem [0:4095];
    logic [11:0] addr_s;
    int          ack_delay = 0;
    int          total = 0, bad = 0;
    int          cyc = 0, req_cnt = 0, done_cnt = 0, bad_busy = 0, unstable = 0, req_hi = 0;
    logic        req_prev = 1'b0;
    logic [19:0] addr_prev = '0;
    wrec_t       wq[$];
    logic [19:0] rq[$];

    function automatic logic [63:0] rom_fn(input logic [19:0] a);
        return {a[19:4] ^ 16'h8001, a[15:0] ^ 16'hA5C3, a[19:4] ^ 16'h7F10, a[15:0] + 16'h1357};
    endfunction

    function automatic logic [63:0] rev_planes(input logic [63:0] d);
        logic [63:0] r;
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 16; i++)
                r[p*16+i] = d[p*16+15-i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // attribute RAM: registered read, data one clk after address
    initial begin
        obj_data = '0;
        forever begin
            @(negedge clk) addr_s = obj_addr;
            @(posedge clk) #1 obj_data = attr_mem[addr_s];
        end
    end

    // ROM responder with programmable latency
    initial begin
        int wcnt;
        wcnt = 0;
        rom_ack = 1'b0;
        rom_data = '0;
        forever begin
            @(posedge clk); #1;
            rom_ack = 1'b0;
            if (rom_req) begin
                if (wcnt >= ack_delay) begin
                    rom_ack  = 1'b1;
                    rom_data = rom_fn(rom_addr);
                    wcnt     = 0;
                end else wcnt++;
            end else wcnt = 0;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (we) wq.push_back('{b: bits, c: color, p: prio, x: pos, cyc: cyc});
            if (rom_req && !req_prev) begin req_cnt++; rq.push_back(rom_addr); end
            if (rom_req && req_prev && rom_addr != addr_prev) unstable++;
            if (rom_req) req_hi++;
            if (done) begin done_cnt++; if (busy) bad_busy++; end
            req_prev  = rom_req;
            addr_prev = rom_addr;
        end
    end

    task automatic set_sprite(input int i, input int y, input int h, input int w, input int code,
                              input int col, input int pr, input int fx, input int fy, input int x);
        attr_mem[4*i+0] = 16'((w << 11) | (h << 9) | y);
        attr_mem[4*i+1] = 16'(code);
        attr_mem[4*i+2] = 16'((fy << 9) | (fx << 8) | (pr << 7) | col);
        attr_mem[4*i+3] = 16'(x);
    endtask

    task automatic hide_all();
        for (int i = 0; i < NS; i++) set_sprite(i, 300, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pulse_start(input logic [8:0] l);
        @(negedge clk) begin start = 1'b1; line = l; end
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 3000) begin @(posedge clk); n++; end
        chk("done_in_budget", 64'(n < 3000), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    int w0, r0, d0, h0, u0, nexp;
    logic [19:0] ea;
    logic [15:0] tl;
    int mingap;

    task automatic mark();
        w0 = wq.size(); r0 = req_cnt; d0 = done_cnt; h0 = req_hi; u0 = unstable;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; line = '0;
        for (int i = 0; i < 4096; i++) attr_mem[i] = '0;
        hide_all();
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_rom_req", 64'(rom_req), 0);
        chk("rst_we", 64'(we), 0);
        chk("rst_obj_addr", 64'(obj_addr), 0);

        // basic single-column sprite
        set_sprite(0, 100, 0, 0, 16'h1234, 5, 1, 0, 0, 50);
        mark(); pulse_start(9'd107); wait_done(d0);
        chk("t1_nwe", 64'(wq.size() - w0), 1);
        chk("t1_nreq", 64'(req_cnt - r0), 1);
        chk("t1_addr", 64'(rq[r0]), 64'h12347);
        chk("t1_pos", 64'(wq[w0].x), 50);
        chk("t1_color", 64'(wq[w0].c), 5);
        chk("t1_prio", 64'(wq[w0].p), 1);
        chk("t1_bits", wq[w0].b, rom_fn(20'h12347));
        chk("t1_done_cnt", 64'(done_cnt - d0), 1);
        chk("t1_busy_at_done", 64'(bad_busy), 0);

        // four columns, flipx, x wrap
        set_sprite(0, 0, 0, 2, 0, 3, 0, 1, 0, 1020);
        mark(); pulse_start(9'd5); wait_done(d0);
        chk("t2_nwe", 64'(wq.size() - w0), 4);
        mingap = 1000;
        for (int c = 0; c < 4; c++) begin
            tl = 16'(8 * (3 - c));
            ea = {tl, 4'h5};
            chk("t2_addr", 64'(rq[r0+c]), 64'(ea));
            chk("t2_pos", 64'(wq[w0+c].x), 64'((1020 + 16 * c) % 1024));
            chk("t2_bits", wq[w0+c].b, rev_planes(rom_fn(ea)));
            if (c > 0 && wq[w0+c].cyc - wq[w0+c-1].cyc < mingap) mingap = wq[w0+c].cyc - wq[w0+c-1].cyc;
        end
        chk("t2_gap_ge8", 64'(mingap >= 8), 1);

        // flipy on 32-line sprite
        hide_all();
        set_sprite(0, 200, 1, 0, 16'h0100, 1, 0, 0, 1, 0);
        mark(); pulse_start(9'd200); wait_done(d0);
        chk("t3_addr", 64'(rq[r0]), 64'h0101F);
        chk("t3_nwe", 64'(wq.size() - w0), 1);

        // slow ROM
        set_sprite(0, 100, 0, 0, 16'h1234, 5, 1, 0, 0, 50);
        ack_delay = 20;
        mark(); pulse_start(9'd107); wait_done(d0);
        chk("t4_stable", 64'(unstable - u0), 0);
        chk("t4_req_hold", 64'((req_hi - h0) >= 20), 1);
        chk("t4_nwe", 64'(wq.size() - w0), 1);

        // restart while waiting on ROM
        mark(); pulse_start(9'd107);
        begin
            int n;
            n = 0;
            while (!rom_req && n < 500) begin @(negedge clk); n++; end
            chk("t4r_req_seen", 64'(n < 500), 1);
        end
        repeat (5) @(negedge clk);
        pulse_start(9'd107);
        wait_done(d0);
        chk("t4r_nwe", 64'(wq.size() - w0), 1);
        chk("t4r_nreq", 64'(req_cnt - r0), 2);
        chk("t4r_done", 64'(done_cnt - d0), 1);
        chk("t4r_stable", 64'(unstable - u0), 0);
        ack_delay = 0;

        // vertical wrap
        set_sprite(0, 510, 0, 0, 16'h0040, 2, 0, 0, 0, 7);
        mark(); pulse_start(9'd3); wait_done(d0);
        chk("t5_nreq", 64'(req_cnt - r0), 1);
        chk("t5_addr", 64'(rq[r0]), 64'h00405);
        chk("t5_pos", 64'(wq[w0].x), 7);
        mark(); pulse_start(9'd16); wait_done(d0);
        chk("t5b_nreq", 64'(req_cnt - r0), 0);
        chk("t5b_nwe", 64'(wq.size() - w0), 0);
        chk("t5b_done", 64'(done_cnt - d0), 1);

        // three visible sprites on one line
        hide_all();
        set_sprite(0, 0, 0, 0, 16'h0010, 1, 0, 0, 0, 0);
        set_sprite(1, 0, 0, 0, 16'h0020, 2, 0, 0, 0, 100);
        set_sprite(2, 0, 0, 0, 16'h0030, 3, 0, 0, 0, 200);
`ifdef GA22_SPRITE_LIMIT_EN
        nexp = MAXS;
`else
        nexp = 3;
`endif
        mark(); pulse_start(9'd1); wait_done(d0);
        chk("t6_nwe", 64'(wq.size() - w0), 64'(nexp));
        chk("t6_nreq", 64'(req_cnt - r0), 64'(nexp));
        chk("t6_pos1", 64'(wq[w0+1].x), 100);
        chk("t6_done", 64'(done_cnt - d0), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
